// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in serial-out transmitter.
package piso_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } piso_state_e;

   // Even parity bit: 1 when the word holds an odd number of ones.
   function automatic logic even_parity(input logic [31:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// WIDTH-bit right-shifting datapath register with load priority over shift.
module piso_shift_reg #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift_en,
   input  logic [WIDTH-1:0] d,
   output logic             lsb,
   output logic             nxt_lsb
);

   logic [WIDTH-1:0] q_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= '0;
      end else if (load) begin
         q_q <= d;
      end else if (shift_en) begin
         q_q <= {1'b0, q_q[WIDTH-1:1]};
      end
   end

   // Bit 1 is exposed so the controller can register the post-shift line value.
   assign lsb     = q_q[0];
   assign nxt_lsb = q_q[1];

endmodule

// File: rtl/piso_tx_ctrl.sv
// Frame sequencer: start bit, LSB-first data, optional even parity, stop bit.
module piso_tx_ctrl #(
   parameter int unsigned WIDTH        = 8,
   parameter int unsigned CLKS_PER_BIT = 4,
   parameter int unsigned PARITY_EN    = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             serial_out,
   output logic             busy,
   output logic             done
);
   import piso_pkg::*;

   localparam int unsigned DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned BIT_W = $clog2(WIDTH);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

   piso_state_e      state_q, state_nxt;
   logic [DIV_W-1:0] div_q, div_nxt;
   logic [BIT_W-1:0] bit_q, bit_nxt;
   logic             parity_q;
   logic             hs;
   logic             div_tc;
   logic             sh_load, sh_shift;
   logic             sh_lsb, sh_nxt_lsb;
   logic             serial_nxt;
   logic             done_nxt;

   assign hs     = in_valid && in_ready;
   assign div_tc = (div_q == DIV_LAST);

   piso_shift_reg #(.WIDTH(WIDTH)) u_shift (
      .clk      (clk),
      .rst      (rst),
      .load     (sh_load),
      .shift_en (sh_shift),
      .d        (in_data),
      .lsb      (sh_lsb),
      .nxt_lsb  (sh_nxt_lsb)
   );

   // State, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         div_q      <= '0;
         bit_q      <= '0;
         parity_q   <= 1'b0;
         serial_out <= 1'b1;
         in_ready   <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state_q    <= state_nxt;
         div_q      <= div_nxt;
         bit_q      <= bit_nxt;
         parity_q   <= hs ? even_parity(32'(in_data)) : parity_q;
         serial_out <= serial_nxt;
         in_ready   <= (state_nxt == ST_IDLE);
         busy       <= (state_nxt != ST_IDLE);
         done       <= done_nxt;
      end
   end

   // Next state, counter sequencing and next line value.
   always_comb begin
      state_nxt = state_q;
      div_nxt   = div_q;
      bit_nxt   = bit_q;
      sh_load   = 1'b0;
      sh_shift  = 1'b0;
      done_nxt  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (hs) begin
               sh_load   = 1'b1;
               state_nxt = ST_START;
               div_nxt   = '0;
               bit_nxt   = '0;
            end
         end
         ST_START: begin
            div_nxt = div_q + DIV_W'(1);
            if (div_tc) begin
               div_nxt   = '0;
               state_nxt = ST_DATA;
            end
         end
         ST_DATA: begin
            div_nxt = div_q + DIV_W'(1);
            if (div_tc) begin
               div_nxt = '0;
               if (bit_q == BIT_LAST) begin
                  bit_nxt   = '0;
                  state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
               end else begin
                  bit_nxt  = bit_q + BIT_W'(1);
                  sh_shift = 1'b1;
               end
            end
         end
         ST_PARITY: begin
            div_nxt = div_q + DIV_W'(1);
            if (div_tc) begin
               div_nxt   = '0;
               state_nxt = ST_STOP;
            end
         end
         ST_STOP: begin
            div_nxt = div_q + DIV_W'(1);
            if (div_tc) begin
               div_nxt   = '0;
               state_nxt = ST_IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            div_nxt   = '0;
            bit_nxt   = '0;
         end
      endcase

      // A shifting edge must present the bit that becomes the new LSB.
      case (state_nxt)
         ST_START:  serial_nxt = 1'b0;
         ST_DATA:   serial_nxt = sh_shift ? sh_nxt_lsb : sh_lsb;
         ST_PARITY: serial_nxt = parity_q;
         default:   serial_nxt = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Randomized bench: three transmitter configurations checked cycle by cycle against a frame model.
module tb_piso_tx_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance 0: 4 clk/bit with parity, 1: 4 clk/bit no parity, 2: 1 clk/bit with parity.
   logic [2:0]      rst;
   logic [2:0]      in_valid;
   logic [2:0][7:0] in_data;
   logic [2:0]      in_ready;
   logic [2:0]      serial_out;
   logic [2:0]      busy;
   logic [2:0]      done;

   int n_checks = 0;
   int n_errors = 0;
   bit exp_line[$];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      piso_tx_ctrl #(
         .WIDTH        (8),
         .CLKS_PER_BIT ((g == 2) ? 1 : 4),
         .PARITY_EN    ((g == 1) ? 0 : 1)
      ) u_dut (
         .clk        (clk),
         .rst        (rst[g]),
         .in_valid   (in_valid[g]),
         .in_data    (in_data[g]),
         .in_ready   (in_ready[g]),
         .serial_out (serial_out[g]),
         .busy       (busy[g]),
         .done       (done[g])
      );
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int cpb_of(input int d);
      return (d == 2) ? 1 : 4;
   endfunction

   function automatic int pen_of(input int d);
      return (d == 1) ? 0 : 1;
   endfunction

   // Expected line, one entry per serial bit slot.
   task automatic model_frame(input int d, input logic [7:0] w);
      exp_line.delete();
      exp_line.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_line.push_back(w[i]);
      if (pen_of(d) != 0) exp_line.push_back(($countones(w) % 2) == 1);
      exp_line.push_back(1'b1);
   endtask

   task automatic idle(input int d, input int n);
      repeat (n) begin
         @(negedge clk);
         chk($sformatf("d%0d idle line", d), serial_out[d], 1);
         chk($sformatf("d%0d idle done", d), done[d], 0);
         chk($sformatf("d%0d idle busy", d), busy[d], 0);
         chk($sformatf("d%0d idle ready", d), in_ready[d], 1);
      end
   endtask

   // Send one word from a negedge where the DUT is ready; return on the done-cycle negedge.
   task automatic tx(input int d, input logic [7:0] w, input bit nxt_v,
                     input logic [7:0] nxt_w, input bit noise);
      int cpb;
      int len;
      cpb = cpb_of(d);
      model_frame(d, w);
      len = exp_line.size() * cpb;
      chk($sformatf("d%0d ready before %0h", d, w), in_ready[d], 1);
      in_valid[d] = 1'b1;
      in_data[d]  = w;
      for (int c = 0; c < len; c++) begin
         @(negedge clk);
         chk($sformatf("d%0d w%0h c%0d line", d, w, c), serial_out[d], exp_line[c / cpb]);
         chk($sformatf("d%0d w%0h c%0d busy", d, w, c), busy[d], 1);
         chk($sformatf("d%0d w%0h c%0d ready", d, w, c), in_ready[d], 0);
         chk($sformatf("d%0d w%0h c%0d done", d, w, c), done[d], 0);
         if (nxt_v) begin
            in_valid[d] = 1'b1;
            in_data[d]  = nxt_w;
         end else if (noise) begin
            in_valid[d] = 1'($urandom);
            in_data[d]  = 8'($urandom);
         end else begin
            in_valid[d] = 1'b0;
         end
      end
      @(negedge clk);
      chk($sformatf("d%0d w%0h end done", d, w), done[d], 1);
      chk($sformatf("d%0d w%0h end line", d, w), serial_out[d], 1);
      chk($sformatf("d%0d w%0h end busy", d, w), busy[d], 0);
      chk($sformatf("d%0d w%0h end ready", d, w), in_ready[d], 1);
      in_valid[d] = nxt_v;
      in_data[d]  = nxt_w;
   endtask

   // Start a frame and assert reset on the negedge of cycle abort_c-1.
   task automatic tx_abort(input int d, input logic [7:0] w, input int abort_c);
      int cpb;
      cpb = cpb_of(d);
      model_frame(d, w);
      in_valid[d] = 1'b1;
      in_data[d]  = w;
      for (int c = 0; c < abort_c; c++) begin
         @(negedge clk);
         chk($sformatf("d%0d abort c%0d line", d, c), serial_out[d], exp_line[c / cpb]);
         in_valid[d] = 1'b0;
      end
      rst[d] = 1'b1;
      @(negedge clk);
      chk($sformatf("d%0d abort line", d), serial_out[d], 1);
      chk($sformatf("d%0d abort ready", d), in_ready[d], 1);
      chk($sformatf("d%0d abort busy", d), busy[d], 0);
      chk($sformatf("d%0d abort done", d), done[d], 0);
      rst[d] = 1'b0;
   endtask

   initial begin
      logic [7:0] cur;
      logic [7:0] nw;
      bit         nv;

      rst      = 3'b111;
      in_valid = '0;
      in_data  = '0;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("d%0d reset line", d), serial_out[d], 1);
         chk($sformatf("d%0d reset ready", d), in_ready[d], 1);
         chk($sformatf("d%0d reset busy", d), busy[d], 0);
         chk($sformatf("d%0d reset done", d), done[d], 0);
      end
      rst = '0;
      idle(0, 2);

      // Directed frames: A5, parity-one word, no-parity frame, back-to-back.
      tx(0, 8'hA5, 1'b0, 8'h00, 1'b0);
      idle(0, 1);
      tx(0, 8'h01, 1'b0, 8'h00, 1'b0);
      idle(0, 1);
      tx(1, 8'h01, 1'b0, 8'h00, 1'b0);
      idle(1, 1);
      tx(0, 8'hFF, 1'b1, 8'h00, 1'b0);
      tx(0, 8'h00, 1'b0, 8'h00, 1'b0);
      idle(0, 2);

      // Reset during data bit 3, then a clean frame.
      tx_abort(0, 8'h5A, 18);
      idle(0, 6);
      tx(0, 8'hC3, 1'b0, 8'h00, 1'b0);
      idle(0, 1);

      // Reset wins over a simultaneous handshake.
      in_valid[2] = 1'b1;
      in_data[2]  = 8'h99;
      rst[2]      = 1'b1;
      @(negedge clk);
      rst[2]      = 1'b0;
      in_valid[2] = 1'b0;
      idle(2, 3);

      // Single-cycle bits with input noise while busy.
      tx(2, 8'h3C, 1'b0, 8'h00, 1'b1);
      idle(2, 1);

      // Randomized frames, random gaps and chaining on every configuration.
      for (int d = 0; d < 3; d++) begin
         cur = 8'($urandom);
         for (int k = 0; k < 8; k++) begin
            nv = (k == 7) ? 1'b0 : 1'($urandom);
            nw = 8'($urandom);
            tx(d, cur, nv, nw, 1'($urandom));
            if (nv) begin
               cur = nw;
            end else begin
               idle(d, int'($urandom_range(0, 3)));
               cur = 8'($urandom);
            end
         end
         idle(d, 2);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/piso_tx_ctrl.md
PISO_TX_CTRL -- requirements
Module: piso_tx_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the payload bits per frame (legal range 2..32).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 4, meaning the clk cycles each serial bit is held (legal range >=1).
REQ-003 SHALL have parameter PARITY_EN, default 1, meaning 1 inserts an even-parity bit after the data and 0 omits it.
REQ-004 SHALL have port clk, input, width 1: the single clock; all logic samples on posedge clk.
REQ-005 SHALL have port rst, input, width 1: reset, synchronous and active-high.
REQ-006 SHALL have port in_valid, input, width 1: a parallel word is offered.
REQ-007 SHALL have port in_data, input, width WIDTH: the parallel word.
REQ-008 SHALL have port in_ready, output, width 1: the block accepts a word this cycle.
REQ-009 SHALL have port serial_out, output, width 1: the registered serial line, idle high.
REQ-010 SHALL have port busy, output, width 1: a frame is in progress.
REQ-011 SHALL have port done, output, width 1: one-cycle pulse when a frame completes.

Function
REQ-012 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, with all outputs registered.
REQ-013 SHALL drive in_ready=1 only in IDLE, and busy=1 in every non-IDLE state.
REQ-014 SHALL treat a handshake as in_valid&&in_ready sampled at posedge; on it, load in_data into the shifter, compute parity=^in_data, and enter START.
REQ-015 SHALL ignore in_data changes after the handshake, and ignore in_valid while busy (no buffering).
REQ-016 SHALL, per state, drive serial_out as: START=0; DATA=shifter[0], LSB first, right shift per bit; PARITY=stored parity; STOP=1; IDLE=1.
REQ-017 SHALL hold each bit exactly CLKS_PER_BIT cycles using a divider counter 0..CLKS_PER_BIT-1, and advance state or bit only on terminal count.
REQ-018 SHALL use a bit counter 0..WIDTH-1 in DATA, leaving DATA after bit WIDTH-1, to PARITY if PARITY_EN else to STOP.
REQ-019 SHALL make serial_out change on the edge that registers the handshake; frame length = (WIDTH+2+PARITY_EN)*CLKS_PER_BIT cycles, counted from that edge to the return to IDLE.
REQ-020 SHALL pulse done for exactly one cycle, coinciding with the first IDLE cycle after STOP.
REQ-021 SHALL accept a new handshake in that same first IDLE cycle, giving a minimum inter-frame gap of one idle-high cycle.
REQ-022 SHALL, when CLKS_PER_BIT=1, hold every bit for one cycle with no divider stall.

Reset
REQ-023 SHALL, while rst=1 at posedge, force state=IDLE, serial_out=1, in_ready=1 (visible from the first cycle after reset), busy=0, done=0, both counters=0, and shifter=0.
REQ-024 SHALL, on rst mid-frame, abort the frame without asserting done, with the line returning high on that edge.
REQ-025 SHALL give rst priority over a simultaneous handshake; the word is dropped.

Structure
REQ-026 SHALL place the state enum and the parity helper function in shared package piso_pkg.
REQ-027 SHALL instantiate sub-module piso_shift_reg (WIDTH-bit, load/shift-enable, synchronous reset) as the datapath, with the controller sequencing load and shift.

Verification
REQ-028 SHALL test WIDTH=8, CLKS_PER_BIT=4, PARITY_EN=1 with word 8'hA5 -> line 0, then 1,0,1,0,0,1,0,1, then parity 0, then 1, each held 4 cycles; done after 44 cycles.
REQ-029 SHALL test 8'h01 with PARITY_EN=1 -> parity bit 1; and PARITY_EN=0 with 8'h01 -> frame of 40 cycles with no parity slot.
REQ-030 SHALL test back-to-back: in_valid held high with 8'hFF then 8'h00 -> second start bit exactly one idle-high cycle after the done pulse.
REQ-031 SHALL test rst asserted during DATA bit 3 -> next cycle serial_out=1, in_ready=1, busy=0, no done, and the next word is transmitted intact.
REQ-032 SHALL test CLKS_PER_BIT=1 with 8'h3C -> 11-cycle frame; also in_data changed and in_valid pulsed while busy -> no effect on the frame.
